// File: rtl/nn_layer_sequencer.sv
// ============================================================================
// Module   : nn_layer_sequencer
// Summary  : Control FSM for a 2-layer NN datapath: weight fill from a stream,
//            then layer-by-layer inference on one shared MAC unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nn_layer_sequencer #(
    parameter int N_IN  = 4,
    parameter int N_HID = 3,
    parameter int N_OUT = 2,
    parameter int AW    = 8,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill,
    input  logic          req,
    output logic          ack,
    output logic          busy,
    output logic          wgt_we,
    output logic [AW-1:0] wgt_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [IW-1:0] in_idx,
    output logic          layer,
    output logic [IW-1:0] neu_idx,
    output logic          act_en,
    output logic          res_we
);

    localparam int c_nw = N_IN*N_HID + N_HID*N_OUT;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_CLR  = 3'd2,
        S_MAC  = 3'd3,
        S_ACT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        r_state, w_state;
    logic [AW-1:0] r_fptr, w_fptr;
    logic [AW-1:0] r_rptr, w_rptr;
    logic [AW-1:0] r_addr, w_addr;
    logic [IW-1:0] r_k, w_k;
    logic [IW-1:0] r_neu, w_neu;
    logic          r_layer, w_layer;
    logic          r_ack, w_ack;
    logic          r_busy, w_busy;
    logic          r_we, w_we;
    logic          r_clr, w_clr;
    logic          r_en, w_en;
    logic          r_act, w_act;
    logic          r_res, w_res;

    logic [IW-1:0] w_fanin_m1;
    logic [IW-1:0] w_last_neu;
    logic [AW-1:0] w_fptr_inc;

    assign w_fanin_m1 = r_layer ? IW'(N_HID - 1) : IW'(N_IN - 1);
    assign w_last_neu = r_layer ? IW'(N_OUT - 1) : IW'(N_HID - 1);
    assign w_fptr_inc = (r_fptr == AW'(c_nw - 1)) ? '0 : r_fptr + AW'(1);

    always_comb begin
        w_state = r_state;
        w_fptr  = r_fptr;
        w_rptr  = r_rptr;
        w_addr  = r_addr;
        w_k     = r_k;
        w_neu   = r_neu;
        w_layer = r_layer;
        w_ack   = 1'b0;
        w_we    = 1'b0;
        w_clr   = 1'b0;
        w_en    = 1'b0;
        w_act   = 1'b0;
        w_res   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fill) begin
                    w_state = S_FILL;
                    w_we    = 1'b1;
                    w_addr  = '0;
                    w_fptr  = (c_nw == 1) ? '0 : AW'(1);
                end else if (req) begin
                    w_state = S_CLR;
                    w_clr   = 1'b1;
                    w_rptr  = '0;
                    w_k     = '0;
                    w_neu   = '0;
                    w_layer = 1'b0;
                end
            end
            S_FILL: begin
                if (fill) begin
                    w_we   = 1'b1;
                    w_addr = r_fptr;
                    w_fptr = w_fptr_inc;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_CLR: begin
                w_state = S_MAC;
                w_en    = 1'b1;
                w_k     = '0;
                w_addr  = r_rptr;
                w_rptr  = r_rptr + AW'(1);
            end
            S_MAC: begin
                if (r_k == w_fanin_m1) begin
                    w_state = S_ACT;
                    w_act   = 1'b1;
                    w_res   = 1'b1;
                end else begin
                    w_en   = 1'b1;
                    w_k    = r_k + IW'(1);
                    w_addr = r_rptr;
                    w_rptr = r_rptr + AW'(1);
                end
            end
            S_ACT: begin
                // The read pointer keeps running across neurons and layers,
                // matching the contiguous weight layout.
                if (r_neu != w_last_neu) begin
                    w_state = S_CLR;
                    w_clr   = 1'b1;
                    w_k     = '0;
                    w_neu   = r_neu + IW'(1);
                end else if (!r_layer) begin
                    w_state = S_CLR;
                    w_clr   = 1'b1;
                    w_k     = '0;
                    w_neu   = '0;
                    w_layer = 1'b1;
                end else begin
                    w_state = S_DONE;
                    w_ack   = 1'b1;
                end
            end
            S_DONE: begin
                if (req) begin
                    w_ack = 1'b1;
                end else begin
                    w_state = S_IDLE;
                    w_k     = '0;
                    w_neu   = '0;
                    w_layer = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fptr  <= '0;
            r_rptr  <= '0;
            r_addr  <= '0;
            r_k     <= '0;
            r_neu   <= '0;
            r_layer <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_clr   <= 1'b0;
            r_en    <= 1'b0;
            r_act   <= 1'b0;
            r_res   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_fptr  <= w_fptr;
            r_rptr  <= w_rptr;
            r_addr  <= w_addr;
            r_k     <= w_k;
            r_neu   <= w_neu;
            r_layer <= w_layer;
            r_ack   <= w_ack;
            r_busy  <= w_busy;
            r_we    <= w_we;
            r_clr   <= w_clr;
            r_en    <= w_en;
            r_act   <= w_act;
            r_res   <= w_res;
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign wgt_we   = r_we;
    assign wgt_addr = r_addr;
    assign mac_clr  = r_clr;
    assign mac_en   = r_en;
    assign in_idx   = r_k;
    assign layer    = r_layer;
    assign neu_idx  = r_neu;
    assign act_en   = r_act;
    assign res_we   = r_res;

endmodule

`default_nettype wire
